// File: rtl/sme_pkg.sv
// rtl/sme_pkg.sv - sizes, character codes and FSM states for the string-matching engine
package sme_pkg;

   localparam int STR_MAX = 32;
   localparam int PAT_MAX = 8;
   localparam int STR_IW  = $clog2(STR_MAX);
   localparam int STR_LW  = STR_IW + 1;
   localparam int PAT_IW  = $clog2(PAT_MAX);
   localparam int PAT_LW  = PAT_IW + 1;
   localparam int WIN_LEN = PAT_MAX + 1;

   localparam logic [7:0] CH_SPACE  = 8'h20;
   localparam logic [7:0] CH_CARET  = 8'h5E;
   localparam logic [7:0] CH_DOLLAR = 8'h24;
   localparam logic [7:0] CH_DOT    = 8'h2E;

   typedef enum logic [1:0] {
      S_IDLE,
      S_LOAD_STR,
      S_LOAD_PAT,
      S_OUT
   } state_e;

endpackage

// File: rtl/sme_pos_cmp.sv
// rtl/sme_pos_cmp.sv - tests the loaded pattern against one start position of the string
module sme_pos_cmp
   import sme_pkg::*;
(
   input  logic [STR_IW-1:0]           pos,
   input  logic [WIN_LEN-1:0][7:0]     win,
   input  logic [STR_LW-1:0]           str_len,
   input  logic [PAT_MAX-1:0][7:0]     pat,
   input  logic [PAT_LW-1:0]           pat_len,
   output logic                        hit
);

   localparam int EW = STR_LW + 1;

   logic              has_caret;
   logic              has_dollar;
   logic              caret_ok;
   logic              body_ok;
   logic              dollar_ok;
   logic [PAT_LW-1:0] body_start;
   logic [PAT_LW-1:0] body_len;
   logic [EW-1:0]     end_pos;
   logic [7:0]        pc;

   // win[0] is the character before pos, win[k+1] is str[pos+k].
   always_comb begin
      has_caret  = (pat_len != '0) && (pat[0] == CH_CARET);
      has_dollar = (pat_len != '0) && (pat[PAT_IW'(pat_len - PAT_LW'(1))] == CH_DOLLAR);
      body_start = has_caret ? PAT_LW'(1) : '0;
      body_len   = pat_len - {{(PAT_LW-1){1'b0}}, has_caret} - {{(PAT_LW-1){1'b0}}, has_dollar};
      caret_ok   = !has_caret || (pos == '0) || (win[0] == CH_SPACE);

      body_ok = 1'b1;
      pc      = '0;
      for (int k = 0; k < PAT_MAX; k++) begin
         if (PAT_LW'(k) < body_len) begin
            pc = pat[PAT_IW'(k) + PAT_IW'(body_start)];
            if ((EW'(pos) + EW'(k)) >= EW'(str_len)) begin
               body_ok = 1'b0;
            end else if ((pc != CH_DOT) && (pc != win[k+1])) begin
               body_ok = 1'b0;
            end
         end
      end

      end_pos   = EW'(pos) + EW'(body_len);
      dollar_ok = !has_dollar || (end_pos == EW'(str_len)) ||
                  ((end_pos < EW'(str_len)) && (win[body_len + PAT_LW'(1)] == CH_SPACE));

      hit = (pat_len != '0) && caret_ok && body_ok && dollar_ok;
   end

endmodule

// File: rtl/sme.sv
// rtl/sme.sv - string-matching engine: serial string/pattern load, parallel match, priority encode
module sme
   import sme_pkg::*;
(
   input  logic              clk,
   input  logic              reset,
   input  logic [7:0]        chardata,
   input  logic              isstring,
   input  logic              ispattern,
   output logic              valid,
   output logic              match,
   output logic [STR_IW-1:0] match_index
);

   state_e                       state_q, state_d;
   logic [STR_MAX-1:0][7:0]      str_q, str_d;
   logic [STR_LW-1:0]            str_len_q, str_len_d;
   logic [PAT_MAX-1:0][7:0]      pat_q, pat_d;
   logic [PAT_LW-1:0]            pat_len_q, pat_len_d;
   logic                         valid_q, valid_d;
   logic                         match_q, match_d;
   logic [STR_IW-1:0]            match_index_q, match_index_d;

   logic [STR_MAX-1:0]           hits;
   logic                         any_hit;
   logic [STR_IW-1:0]            hit_index;

   genvar gp, gj;
   for (gp = 0; gp < STR_MAX; gp++) begin : g_pos
      logic [WIN_LEN-1:0][7:0] win;
      for (gj = 0; gj < WIN_LEN; gj++) begin : g_win
         if ((gp + gj - 1 >= 0) && (gp + gj - 1 < STR_MAX)) begin : g_in
            assign win[gj] = str_q[gp+gj-1];
         end else begin : g_out
            assign win[gj] = 8'h00;
         end
      end
      sme_pos_cmp u_cmp (
         .pos     (STR_IW'(gp)),
         .win     (win),
         .str_len (str_len_q),
         .pat     (pat_q),
         .pat_len (pat_len_q),
         .hit     (hits[gp])
      );
   end

   always_comb begin
      any_hit   = |hits;
      hit_index = '0;
      for (int i = STR_MAX - 1; i >= 0; i--) begin
         if (hits[i]) hit_index = STR_IW'(i);
      end
   end

   // Evaluation happens in the cycle ispattern drops; the result is held for one cycle in S_OUT.
   always_comb begin
      state_d       = state_q;
      str_d         = str_q;
      str_len_d     = str_len_q;
      pat_d         = pat_q;
      pat_len_d     = pat_len_q;
      valid_d       = 1'b0;
      match_d       = 1'b0;
      match_index_d = '0;
      case (state_q)
         S_IDLE, S_LOAD_STR: begin
            if (isstring) begin
               if (state_q == S_IDLE) begin
                  str_d     = '0;
                  str_d[0]  = chardata;
                  str_len_d = STR_LW'(1);
                  state_d   = S_LOAD_STR;
               end else if (str_len_q < STR_LW'(STR_MAX)) begin
                  str_d[str_len_q[STR_IW-1:0]] = chardata;
                  str_len_d = str_len_q + STR_LW'(1);
               end
            end else if (ispattern) begin
               pat_d     = '0;
               pat_d[0]  = chardata;
               pat_len_d = PAT_LW'(1);
               state_d   = S_LOAD_PAT;
            end else begin
               state_d = S_IDLE;
            end
         end
         S_LOAD_PAT: begin
            if (ispattern) begin
               if (pat_len_q < PAT_LW'(PAT_MAX)) begin
                  pat_d[pat_len_q[PAT_IW-1:0]] = chardata;
                  pat_len_d = pat_len_q + PAT_LW'(1);
               end
            end else begin
               valid_d       = 1'b1;
               match_d       = any_hit;
               match_index_d = any_hit ? hit_index : '0;
               state_d       = S_OUT;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         state_q       <= S_IDLE;
         str_q         <= '0;
         str_len_q     <= '0;
         pat_q         <= '0;
         pat_len_q     <= '0;
         valid_q       <= 1'b0;
         match_q       <= 1'b0;
         match_index_q <= '0;
      end else begin
         state_q       <= state_d;
         str_q         <= str_d;
         str_len_q     <= str_len_d;
         pat_q         <= pat_d;
         pat_len_q     <= pat_len_d;
         valid_q       <= valid_d;
         match_q       <= match_d;
         match_index_q <= match_index_d;
      end
   end

   assign valid       = valid_q;
   assign match       = match_q;
   assign match_index = match_index_q;

endmodule

// File: tb/tb_sme.sv
// tb/tb_sme.sv - directed scoreboard bench for the string-matching engine
module tb_sme;

   typedef struct {
      logic       m;
      logic [4:0] idx;
      string      name;
   } exp_t;

   logic       clk = 1'b0;
   logic       reset;
   logic [7:0] chardata;
   logic       isstring;
   logic       ispattern;
   logic       valid;
   logic       match;
   logic [4:0] match_index;

   int   errors = 0;
   int   checks = 0;
   exp_t sb[$];

   sme dut (
      .clk         (clk),
      .reset       (reset),
      .chardata    (chardata),
      .isstring    (isstring),
      .ispattern   (ispattern),
      .valid       (valid),
      .match       (match),
      .match_index (match_index)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic load_string(input string s);
      for (int i = 0; i < s.len(); i++) begin
         @(negedge clk);
         isstring = 1'b1;
         chardata = s[i];
      end
      @(negedge clk);
      isstring = 1'b0;
      chardata = 8'h00;
   endtask

   task automatic run_pattern(input string p, input logic em, input logic [4:0] ei);
      exp_t e;
      int   lat;
      e.m = em;
      e.idx = ei;
      e.name = p;
      sb.push_back(e);
      for (int i = 0; i < p.len(); i++) begin
         @(negedge clk);
         ispattern = 1'b1;
         chardata  = p[i];
      end
      @(negedge clk);
      ispattern = 1'b0;
      chardata  = 8'h00;
      check({p, " early_valid"}, 32'(valid), 32'd0);
      lat = 0;
      while (valid !== 1'b1 && lat < 8) begin
         @(negedge clk);
         lat++;
      end
      check({p, " latency"}, 32'(lat), 32'd1);
      if (sb.size() > 0) begin
         e = sb.pop_front();
         if (valid === 1'b1) begin
            check({e.name, " match"}, 32'(match), 32'(e.m));
            check({e.name, " index"}, 32'(match_index), 32'(e.idx));
         end
      end
      @(negedge clk);
      check({p, " valid_pulse"}, 32'(valid), 32'd0);
      check({p, " idle_outputs"}, {30'd0, match, 1'b0} | 32'(match_index), 32'd0);
   endtask

   initial begin
      int vcount;
      reset     = 1'b0;
      isstring  = 1'b0;
      ispattern = 1'b0;
      chardata  = 8'h00;
      repeat (3) @(negedge clk);
      check("reset valid", 32'(valid), 32'd0);
      check("reset match", 32'(match), 32'd0);
      check("reset index", 32'(match_index), 32'd0);
      reset = 1'b1;

      load_string("the quick brown fox");
      run_pattern("quick", 1'b1, 5'd4);
      run_pattern("q.ick", 1'b1, 5'd4);
      run_pattern("^bro",  1'b1, 5'd10);
      run_pattern("^he",   1'b0, 5'd0);
      run_pattern("^the",  1'b1, 5'd0);
      run_pattern("own$",  1'b1, 5'd12);
      run_pattern("fox$",  1'b1, 5'd16);
      run_pattern("ox.",   1'b0, 5'd0);
      run_pattern("o",     1'b1, 5'd12);
      run_pattern("the",   1'b1, 5'd0);

      load_string("aa");
      run_pattern("a$", 1'b1, 5'd1);

      load_string("0123456789abcdefghijklmnopqrsxyz");
      run_pattern("z$", 1'b1, 5'd31);

      load_string("abcdefgh");
      run_pattern("^.......", 1'b1, 5'd0);

      load_string("a");
      run_pattern("b", 1'b0, 5'd0);

      // Reset in the middle of a pattern load must discard it.
      load_string("the quick brown fox");
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         ispattern = 1'b1;
         chardata  = 8'h71 + 8'(i * 4);
      end
      @(negedge clk);
      reset     = 1'b0;
      ispattern = 1'b0;
      chardata  = 8'h00;
      repeat (2) @(negedge clk);
      reset  = 1'b1;
      vcount = 0;
      for (int i = 0; i < 6; i++) begin
         @(negedge clk);
         if (valid !== 1'b0) vcount++;
      end
      check("post_reset no_valid", 32'(vcount), 32'd0);
      check("post_reset match", 32'(match), 32'd0);
      check("post_reset index", 32'(match_index), 32'd0);

      load_string("the quick brown fox");
      run_pattern("quick", 1'b1, 5'd4);

      check("scoreboard drained", 32'(sb.size()), 32'd0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
